router_pkt_tx: RTL and testbench
================================

Name: router_pkt_tx

Overview:
- Packet source that drives the router's input port: data_out feeds the router's data_in, pkt_valid feeds packet_valid, and the router's busy is an input.
- Payload bytes are staged into an internal buffer while idle. On start, the block emits a header byte, then the payload, then a parity byte, honouring busy stalls.
- Used as the host-side transmitter and as the stimulus engine in the router subsystem.

Parameters:
- MAX_LEN, 63, payload buffer depth in bytes; maximum legal pl_len. Header length field is 6 bits, so MAX_LEN ≤ 63.
- GAP_CYCLES, 2, idle cycles with pkt_valid=0 after the parity transfer and before the next start is accepted. Legal range 1..15.

Ports:
- clock  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- ld_valid  in  1  payload byte load strobe
- ld_data  in  8  payload byte
- ld_ready  out  1  load accepted this cycle when ld_valid=1
- start  in  1  request to send the staged packet
- dest_addr  in  2  destination port 0..2
- pl_len  in  6  payload length in bytes
- start_ready  out  1  high in IDLE
- start_err  out  1  one-cycle pulse: start rejected
- abort  in  1  cancel the current packet (driven from the router soft-reset path)
- busy  in  1  router busy; a byte transfers only on a posedge with busy=0
- data_out  out  8  byte to router
- pkt_valid  out  1  high during header and payload; low during parity
- tx_done  out  1  one-cycle pulse when the parity byte transfers
- buf_count  out  7  bytes currently staged

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; buffer pointers and buf_count go to 0.
  - data_out=0, pkt_valid=0, tx_done=0, start_err=0.
  - start_ready=1 and ld_ready=1 from the first cycle after reset.
- Load path:
  - ld_ready = (state==IDLE) && (buf_count<MAX_LEN) && !start.
  - A write occurs when ld_valid && ld_ready; buf_count increments next cycle.
  - start has priority: a ld_valid in the same cycle as start is dropped.
- Start acceptance:
  - Evaluated in IDLE on start=1, using the pre-write buf_count.
  - Rejected if pl_len==0, dest_addr==3, or pl_len!=buf_count. On rejection: start_err pulses next cycle, state stays IDLE, buffer is unchanged.
  - If accepted: latch dest_addr and pl_len, form header={pl_len,dest_addr}, seed parity with the header, go to HEADER.
- States (transfer = posedge with busy=0):
  - IDLE: pkt_valid=0, data_out=0.
  - HEADER: data_out=header, pkt_valid=1. On transfer, go to PAYLOAD.
  - PAYLOAD: data_out=buf[rd_ptr], pkt_valid=1. On transfer: parity ^= byte, rd_ptr++, buf_count--. After the pl_len-th transfer, go to PARITY.
  - PARITY: data_out=parity (XOR of header and all payload bytes), pkt_valid=0. On transfer: tx_done pulses next cycle, go to GAP.
  - GAP: pkt_valid=0, data_out=0. Count GAP_CYCLES, then go to IDLE.
- Outputs are registered: data_out and pkt_valid change only on posedge.
- busy=1: data_out and pkt_valid hold their values indefinitely; no pointer or parity update.
- busy during GAP or IDLE is ignored.
- abort (priority below reset, above everything else):
  - From any state, go to IDLE next cycle.
  - pkt_valid=0, data_out=0, buffer flushed (buf_count=0), no tx_done.
  - Takes effect even while busy=1.
- Pointers wrap modulo buffer depth. Both pointers reset to 0 at each packet end, so no wrap-around occurs across packets.
- When buf_count==MAX_LEN, ld_ready=0 and further ld_valid is ignored with no error.

Optional Feature:
- Macro: ROUTER_TX_PARITY_INJECT_EN.
- When defined: adds input inj_err (1 bit), sampled at start acceptance. If inj_err=1, the transmitted parity byte is ~parity; otherwise the byte is unchanged. Used to exercise the router's parity-error path.
- When undefined: no inj_err port; parity is always correct.

Decomposition:
- Shared package router_pkg:
  - State encodings (TX_IDLE..TX_GAP).
  - Header field positions (ADDR LSB 0, width 2; LEN LSB 2, width 6).
  - Constant INVALID_ADDR=2'b11.
- Sub-module router_tx_buf: MAX_LEN×8 register array with write/read pointers, buf_count, and flush.
- The FSM and parity logic live in router_pkt_tx.

Test Plan:
- Basic send:
  - Stimulus: after reset, load 0x11,0x22,0x33; start with dest_addr=1, pl_len=3, busy=0.
  - Response: data_out sequence 0x0D(pv=1), 0x11, 0x22, 0x33, then 0x0D(pv=0); tx_done pulses once; idle for 2 cycles; start_ready=1.
- Busy stall:
  - Stimulus: same packet, busy=1 for 4 cycles starting at the first payload byte.
  - Response: 0x11 is held for 5 cycles; no byte is duplicated or dropped; parity is still 0x0D.
- Rejection:
  - Stimulus: start with dest_addr=3; then start with pl_len=0; then start with pl_len=2 while buf_count=3.
  - Response: each gives a one-cycle start_err pulse; pkt_valid stays 0; buf_count stays 3.
- Abort:
  - Stimulus: assert abort during payload byte 2 of a 10-byte packet.
  - Response: pkt_valid=0 the next cycle, buf_count=0, no tx_done; a new 1-byte packet then sends correctly.
- Boundary:
  - Stimulus: load 64 bytes of value i.
  - Response: only 63 are accepted (buf_count=63, ld_ready=0); a 63-byte packet to port 2 gives header 0xFE, and parity equals 0xFE XOR the XOR of 0..62.
- Inject (with ROUTER_TX_PARITY_INJECT_EN defined):
  - Stimulus: send the basic packet with inj_err=1.
  - Response: parity byte is 0xF2.

Source files
------------

// File: rtl/router_pkg.sv
// Shared encodings for the router packet transmitter: FSM states, header layout, invalid port.
package router_pkg;

    localparam logic [2:0] TX_IDLE    = 3'd0;
    localparam logic [2:0] TX_HEADER  = 3'd1;
    localparam logic [2:0] TX_PAYLOAD = 3'd2;
    localparam logic [2:0] TX_PARITY  = 3'd3;
    localparam logic [2:0] TX_GAP     = 3'd4;

    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_W   = 2;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_LEN_W    = 6;

    localparam logic [1:0] INVALID_ADDR = 2'b11;

    function automatic logic [7:0] make_hdr(input logic [5:0] len, input logic [1:0] addr);
        logic [7:0] h;
        h = '0;
        h[HDR_LEN_LSB +: HDR_LEN_W]   = len;
        h[HDR_ADDR_LSB +: HDR_ADDR_W] = addr;
        return h;
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload staging buffer: MAX_LEN x 8 registers, wrapping write/read pointers, occupancy count.
// Zero-latency combinational read of the current and next read slot; flush wins over write/read.
module router_tx_buf #(
    parameter int MAX_LEN = 63
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    input  logic       flush,
    output logic [7:0] rd_data,
    output logic [7:0] rd_data_nxt,
    output logic [6:0] count
);

    localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic [7:0]    mem_q [MAX_LEN];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] rd_ptr_inc;
    logic [6:0]    count_q, count_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_LEN - 1)) ? '0 : p + PW'(1);
    endfunction

    assign rd_ptr_inc  = ptr_inc(rd_ptr_q);
    assign rd_data     = mem_q[rd_ptr_q];
    assign rd_data_nxt = mem_q[rd_ptr_inc];
    assign count       = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (rd_en) rd_ptr_d = rd_ptr_inc;
            count_d = count_q + {6'd0, wr_en} - {6'd0, rd_en};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset: contents are only read below count.
    always_ff @(posedge clock) begin
        if (wr_en && !flush) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port packet source: header, staged payload, then XOR parity; registered outputs,
// held while busy=1. Optional ROUTER_TX_PARITY_INJECT_EN adds inj_err to corrupt the parity byte.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int MAX_LEN    = 63,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ld_valid,
    input  logic [7:0] ld_data,
    output logic       ld_ready,
    input  logic       start,
    input  logic [1:0] dest_addr,
    input  logic [5:0] pl_len,
    output logic       start_ready,
    output logic       start_err,
    input  logic       abort,
    input  logic       busy,
`ifdef ROUTER_TX_PARITY_INJECT_EN
    input  logic       inj_err,
`endif
    output logic [7:0] data_out,
    output logic       pkt_valid,
    output logic       tx_done,
    output logic [6:0] buf_count
);

    logic [2:0] state_q, state_d;
    logic [5:0] len_q, len_d;
    logic [5:0] cnt_q, cnt_d;
    logic [3:0] gap_q, gap_d;
    logic [7:0] par_q, par_d;
    logic [7:0] data_q, data_d;
    logic       pv_q, pv_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [7:0] inj_mask;

    logic       buf_wr, buf_rd, buf_flush;
    logic [7:0] rd_data, rd_data_nxt;
    logic       xfer, start_ok;
    logic [7:0] hdr;

`ifdef ROUTER_TX_PARITY_INJECT_EN
    logic inj_q, inj_d;
    assign inj_mask = {8{inj_q}};
`else
    assign inj_mask = 8'h00;
`endif

    assign xfer        = !busy;
    assign hdr         = make_hdr(pl_len, dest_addr);
    assign start_ok    = (pl_len != 6'd0) && (dest_addr != INVALID_ADDR) && ({1'b0, pl_len} == buf_count);
    assign ld_ready    = (state_q == TX_IDLE) && (buf_count < 7'(MAX_LEN)) && !start;
    assign buf_wr      = ld_valid && ld_ready;
    assign start_ready = (state_q == TX_IDLE);
    assign start_err   = err_q;
    assign data_out    = data_q;
    assign pkt_valid   = pv_q;
    assign tx_done     = done_q;

    router_tx_buf #(.MAX_LEN(MAX_LEN)) u_buf (
        .clock       (clock),
        .reset       (reset),
        .wr_en       (buf_wr),
        .wr_data     (ld_data),
        .rd_en       (buf_rd),
        .flush       (buf_flush),
        .rd_data     (rd_data),
        .rd_data_nxt (rd_data_nxt),
        .count       (buf_count)
    );

    // Next-cycle output values are computed here so data_out/pkt_valid come straight from flops.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        par_d     = par_q;
        data_d    = data_q;
        pv_d      = pv_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        buf_rd    = 1'b0;
        buf_flush = 1'b0;
`ifdef ROUTER_TX_PARITY_INJECT_EN
        inj_d     = inj_q;
`endif
        case (state_q)
            TX_IDLE: begin
                if (start) begin
                    if (start_ok) begin
                        state_d = TX_HEADER;
                        len_d   = pl_len;
                        cnt_d   = '0;
                        par_d   = hdr;
                        data_d  = hdr;
                        pv_d    = 1'b1;
`ifdef ROUTER_TX_PARITY_INJECT_EN
                        inj_d   = inj_err;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            TX_HEADER: begin
                if (xfer) begin
                    state_d = TX_PAYLOAD;
                    data_d  = rd_data;
                end
            end
            TX_PAYLOAD: begin
                if (xfer) begin
                    buf_rd = 1'b1;
                    par_d  = par_q ^ rd_data;
                    cnt_d  = cnt_q + 6'd1;
                    if (cnt_q == len_q - 6'd1) begin
                        state_d = TX_PARITY;
                        data_d  = par_q ^ rd_data ^ inj_mask;
                        pv_d    = 1'b0;
                    end else begin
                        data_d = rd_data_nxt;
                    end
                end
            end
            TX_PARITY: begin
                if (xfer) begin
                    state_d   = TX_GAP;
                    done_d    = 1'b1;
                    data_d    = '0;
                    gap_d     = '0;
                    buf_flush = 1'b1;
                end
            end
            TX_GAP: begin
                if (gap_q == 4'(GAP_CYCLES - 1)) state_d = TX_IDLE;
                else                             gap_d   = gap_q + 4'd1;
            end
            default: begin
                state_d = TX_IDLE;
                data_d  = '0;
                pv_d    = 1'b0;
            end
        endcase

        if (abort) begin
            state_d   = TX_IDLE;
            data_d    = '0;
            pv_d      = 1'b0;
            done_d    = 1'b0;
            err_d     = 1'b0;
            buf_rd    = 1'b0;
            buf_flush = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= TX_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            par_q   <= '0;
            data_q  <= '0;
            pv_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            par_q   <= par_d;
            data_q  <= data_d;
            pv_q    <= pv_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef ROUTER_TX_PARITY_INJECT_EN
    always_ff @(posedge clock) begin
        if (reset) inj_q <= 1'b0;
        else       inj_q <= inj_d;
    end
`endif

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed + randomized bench for router_pkt_tx against a queue-based packet model.
module tb_router_pkt_tx;

    logic       clock = 1'b0;
    logic       reset;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] pl_len;
    logic       start_ready;
    logic       start_err;
    logic       abort;
    logic       busy;
`ifdef ROUTER_TX_PARITY_INJECT_EN
    logic       inj_err;
`endif
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       tx_done;
    logic [6:0] buf_count;

    router_pkt_tx dut (
        .clock       (clock),
        .reset       (reset),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .start       (start),
        .dest_addr   (dest_addr),
        .pl_len      (pl_len),
        .start_ready (start_ready),
        .start_err   (start_err),
        .abort       (abort),
        .busy        (busy),
`ifdef ROUTER_TX_PARITY_INJECT_EN
        .inj_err     (inj_err),
`endif
        .data_out    (data_out),
        .pkt_valid   (pkt_valid),
        .tx_done     (tx_done),
        .buf_count   (buf_count)
    );

    always #5 clock = ~clock;

    int n_pass = 0;
    int n_fail = 0;
    int n_chk  = 0;

    logic [7:0] mdl_q[$];
    logic [1:0] cur_dest;
    logic [5:0] cur_len;
    logic       cur_inj;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic load(input logic [7:0] b);
        logic exp_rdy;
        exp_rdy  = (mdl_q.size() < 63);
        ld_valid = 1'b1;
        ld_data  = b;
        #1;
        check("ld_ready", ld_ready, exp_rdy);
        step();
        ld_valid = 1'b0;
        if (exp_rdy) mdl_q.push_back(b);
    endtask

    task automatic try_start(input logic [1:0] d, input logic [5:0] len, input logic inj, output logic ok);
        int n;
        n  = mdl_q.size();
        ok = (len != 0) && (d != 2'd3) && (int'(len) == n);
        dest_addr = d;
        pl_len    = len;
`ifdef ROUTER_TX_PARITY_INJECT_EN
        inj_err   = inj;
`endif
        cur_dest = d;
        cur_len  = len;
        cur_inj  = inj;
        start    = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 8'hEE;
        #1;
        check("ld_ready_during_start", ld_ready, 0);
        step();
        start    = 1'b0;
        ld_valid = 1'b0;
        check("start_err", start_err, !ok);
        check("buf_count_after_start", buf_count, n);
        if (!ok) begin
            check("pkt_valid_rejected", pkt_valid, 0);
            step();
            check("start_err_one_cycle", start_err, 0);
            check("start_ready_rejected", start_ready, 1);
        end
    endtask

    // mode 0: never busy, 1: random busy, 2: busy for 4 cycles on first payload byte
    task automatic receive(input int mode, input int abort_at);
        logic [7:0] exp_b[$];
        logic [7:0] par;
        logic       b;
        int idx, cyc, held, stall, total;
        par = {cur_len, cur_dest};
        exp_b.push_back(par);
        foreach (mdl_q[i]) begin
            exp_b.push_back(mdl_q[i]);
            par = par ^ mdl_q[i];
        end
        if (cur_inj) par = ~par;
        exp_b.push_back(par);
        total = int'(cur_len) + 2;
        idx = 0; cyc = 0; held = 0; stall = 0;
        while (idx < total && cyc < 3000) begin
            check($sformatf("data_out[%0d]", idx), data_out, exp_b[idx]);
            check($sformatf("pkt_valid[%0d]", idx), pkt_valid, (idx <= int'(cur_len)));
            check("tx_done_mid", tx_done, 0);
            if (idx == abort_at) begin
                abort = 1'b1;
                busy  = 1'($urandom_range(0, 1));
                step();
                abort = 1'b0;
                busy  = 1'b0;
                check("abort_pkt_valid", pkt_valid, 0);
                check("abort_data_out", data_out, 0);
                check("abort_buf_count", buf_count, 0);
                check("abort_tx_done", tx_done, 0);
                check("abort_start_ready", start_ready, 1);
                step();
                check("abort_tx_done_later", tx_done, 0);
                mdl_q.delete();
                return;
            end
            case (mode)
                1:       b = ($urandom_range(0, 3) == 0);
                2:       b = (idx == 1) && (stall < 4);
                default: b = 1'b0;
            endcase
            busy = b;
            held++;
            step();
            cyc++;
            if (b) begin
                if (idx == 1) stall++;
            end else begin
                if (mode == 2 && idx == 1) check("hold_cycles_first_payload", held, 5);
                idx++;
                held = 0;
            end
        end
        if (idx < total) begin
            check("packet_timeout", 0, 1);
        end else begin
            busy = 1'($urandom_range(0, 1));
            check("tx_done_pulse", tx_done, 1);
            check("gap_pkt_valid", pkt_valid, 0);
            check("gap_data_out", data_out, 0);
            check("end_buf_count", buf_count, 0);
            check("gap_start_ready0", start_ready, 0);
            step();
            check("tx_done_one_cycle", tx_done, 0);
            check("gap_start_ready1", start_ready, 0);
            step();
            busy = 1'b0;
            check("idle_start_ready", start_ready, 1);
            check("idle_ld_ready", ld_ready, 1);
        end
        mdl_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic ok;
        int   len;
        reset = 1'b1; ld_valid = 1'b0; ld_data = '0; start = 1'b0;
        dest_addr = '0; pl_len = '0; abort = 1'b0; busy = 1'b0;
`ifdef ROUTER_TX_PARITY_INJECT_EN
        inj_err = 1'b0;
`endif
        cur_inj = 1'b0;
        @(negedge clock);
        step();
        step();
        reset = 1'b0;
        check("rst_data_out", data_out, 0);
        check("rst_pkt_valid", pkt_valid, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_start_err", start_err, 0);
        check("rst_start_ready", start_ready, 1);
        check("rst_ld_ready", ld_ready, 1);
        check("rst_buf_count", buf_count, 0);

        // basic send
        load(8'h11); load(8'h22); load(8'h33);
        check("basic_buf_count", buf_count, 3);
        try_start(2'd1, 6'd3, 1'b0, ok);
        receive(0, -1);

        // busy stall on first payload byte
        load(8'h11); load(8'h22); load(8'h33);
        try_start(2'd1, 6'd3, 1'b0, ok);
        receive(2, -1);

        // rejections
        load(8'h5A); load(8'hA5); load(8'h3C);
        try_start(2'd3, 6'd3, 1'b0, ok);
        try_start(2'd1, 6'd0, 1'b0, ok);
        try_start(2'd1, 6'd2, 1'b0, ok);
        check("reject_buf_count", buf_count, 3);
        try_start(2'd0, 6'd3, 1'b0, ok);
        receive(1, -1);

        // abort during payload byte 2 of a 10-byte packet
        for (int i = 0; i < 10; i++) load(8'($urandom));
        try_start(2'd2, 6'd10, 1'b0, ok);
        receive(0, 2);
        load(8'hC3);
        try_start(2'd0, 6'd1, 1'b0, ok);
        receive(0, -1);

        // boundary: 64 loads, only 63 fit
        for (int i = 0; i < 64; i++) load(8'(i));
        check("full_buf_count", buf_count, 63);
        #1;
        check("full_ld_ready", ld_ready, 0);
        try_start(2'd2, 6'd63, 1'b0, ok);
        check("full_header", data_out, 8'hFE);
        receive(1, -1);

        // randomized packets
        for (int p = 0; p < 8; p++) begin
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) load(8'($urandom));
            try_start(2'($urandom_range(0, 2)), 6'(len), 1'b0, ok);
            receive(1, -1);
        end

`ifdef ROUTER_TX_PARITY_INJECT_EN
        load(8'h11); load(8'h22); load(8'h33);
        try_start(2'd1, 6'd3, 1'b1, ok);
        receive(0, -1);
        inj_err = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
